// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: MM:SS stopwatch / countdown timer with debounced buttons
// and four 7-segment digit outputs.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   btn_start_n        start/stop button (active-low, asynchronous)
//   btn_lap_n          lap/clear button (active-low, asynchronous)
//   mode_down          0 = count up, 1 = count down from preset
//   preset[15:0]       BCD preset {mt, mu, st, su}
//   seg_mt..seg_su     segments a..g (MSB = a), active-high
//   running            time base advancing
//   lap_hold           display frozen while counting continues
//   done               countdown reached 00:00
//   wrap               one-cycle pulse on 59:59 -> 00:00 in up mode

// Button conditioner: 2-FF synchroniser, debouncer, falling-edge pulse.
module stopwatch_mmss_btn #(
    parameter int DEB_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2, deb, deb_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            cnt   <= '0;
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            deb_d <= deb;
            // Count consecutive samples that disagree with the accepted
            // level; any agreeing sample restarts the count.
            if (s2 != deb) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Press = debounced 1->0; the pulse sits in the cycle after the level
    // flips so the consumer acts on the following edge.
    assign press = deb_d & ~deb;
endmodule

module stopwatch_mmss #(
    parameter int CLK_HZ     = 12000000,
    parameter int DEB_CYCLES = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_n,
    input  logic        btn_lap_n,
    input  logic        mode_down,
    input  logic [15:0] preset,
    output logic [6:0]  seg_mt,
    output logic [6:0]  seg_mu,
    output logic [6:0]  seg_st,
    output logic [6:0]  seg_su,
    output logic        running,
    output logic        lap_hold,
    output logic        done,
    output logic        wrap
);
    localparam int             PW   = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  PMAX = PW'(CLK_HZ - 1);

    logic [1:0]    btn_n, press;
    logic          start_p, lap_p, tick, mode;
    logic [PW-1:0] pre;
    logic [15:0]   tm, lat, inc_t, dec_t, pre_c, disp;

    assign btn_n = {btn_lap_n, btn_start_n};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_btn
            stopwatch_mmss_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
                .clk   (clk),
                .rst   (rst),
                .btn_n (btn_n[g]),
                .press (press[g])
            );
        end
    endgenerate

    assign start_p = press[0];
    assign lap_p   = press[1];
    assign tick    = running && (pre == PMAX);

    function automatic logic [15:0] clamp(input logic [15:0] p);
        clamp[15:12] = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        clamp[11:8]  = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        clamp[7:4]   = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
        clamp[3:0]   = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign pre_c = clamp(preset);

    // BCD increment with carries su -> st -> mu -> mt, 59:59 rolls to 00:00.
    always_comb begin
        inc_t = tm;
        if (tm[3:0] != 4'd9) inc_t[3:0] = tm[3:0] + 4'd1;
        else begin
            inc_t[3:0] = 4'd0;
            if (tm[7:4] != 4'd5) inc_t[7:4] = tm[7:4] + 4'd1;
            else begin
                inc_t[7:4] = 4'd0;
                if (tm[11:8] != 4'd9) inc_t[11:8] = tm[11:8] + 4'd1;
                else begin
                    inc_t[11:8]  = 4'd0;
                    inc_t[15:12] = (tm[15:12] != 4'd5) ? tm[15:12] + 4'd1 : 4'd0;
                end
            end
        end
    end

    // BCD decrement with borrows.
    always_comb begin
        dec_t = tm;
        if (tm[3:0] != 4'd0) dec_t[3:0] = tm[3:0] - 4'd1;
        else begin
            dec_t[3:0] = 4'd9;
            if (tm[7:4] != 4'd0) dec_t[7:4] = tm[7:4] - 4'd1;
            else begin
                dec_t[7:4] = 4'd5;
                if (tm[11:8] != 4'd0) dec_t[11:8] = tm[11:8] - 4'd1;
                else begin
                    dec_t[11:8]  = 4'd9;
                    dec_t[15:12] = (tm[15:12] != 4'd0) ? tm[15:12] - 4'd1 : 4'd5;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tm       <= '0;
            lat      <= '0;
            pre      <= '0;
            mode     <= 1'b0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!running) mode <= mode_down;
            if (running) pre <= tick ? '0 : pre + 1'b1;

            if (tick) begin
                if (!mode) begin
                    tm   <= inc_t;
                    wrap <= (tm == 16'h5959);
                end else begin
                    tm <= dec_t;
                    if (dec_t == 16'h0000) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
            end

            // Start wins over lap when both pulse in the same cycle.
            if (start_p) begin
                if (running) begin
                    running <= 1'b0;
                end else if (mode && tm == 16'h0000) begin
                    tm <= pre_c;
                    if (pre_c == 16'h0000) begin
                        done <= 1'b1;
                    end else begin
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end else begin
                    running <= 1'b1;
                    done    <= 1'b0;
                end
            end else if (lap_p) begin
                if (running) begin
                    lap_hold <= ~lap_hold;
                    // Non-blocking: a coinciding tick still latches pre-tick time.
                    if (!lap_hold) lat <= tm;
                end else begin
                    lap_hold <= 1'b0;
                    done     <= 1'b0;
                    pre      <= '0;
                    tm       <= mode ? pre_c : 16'h0000;
                end
            end
        end
    end

    assign disp   = lap_hold ? lat : tm;
    assign seg_mt = seg7(disp[15:12]);
    assign seg_mu = seg7(disp[11:8]);
    assign seg_st = seg7(disp[7:4]);
    assign seg_su = seg7(disp[3:0]);
endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed bench for stopwatch_mmss with CLK_HZ=10, DEB_CYCLES=4.
module tb_stopwatch_mmss;
    logic        clk = 1'b0;
    logic        rst, btn_start_n, btn_lap_n, mode_down;
    logic [15:0] preset;
    logic [6:0]  seg_mt, seg_mu, seg_st, seg_su;
    logic        running, lap_hold, done, wrap;
    logic [27:0] disp;

    int n_chk = 0;
    int n_fail = 0;

    stopwatch_mmss #(.CLK_HZ(10), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_start_n(btn_start_n), .btn_lap_n(btn_lap_n),
        .mode_down(mode_down), .preset(preset),
        .seg_mt(seg_mt), .seg_mu(seg_mu), .seg_st(seg_st), .seg_su(seg_su),
        .running(running), .lap_hold(lap_hold), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;
    assign disp = {seg_mt, seg_mu, seg_st, seg_su};

    typedef struct {
        logic        md;
        logic [15:0] pre;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [6:0] sg(input logic [3:0] d);
        case (d)
            4'd0: sg = 7'b1111110;  4'd1: sg = 7'b0110000;
            4'd2: sg = 7'b1101101;  4'd3: sg = 7'b1111001;
            4'd4: sg = 7'b0110011;  4'd5: sg = 7'b1011011;
            4'd6: sg = 7'b1011111;  4'd7: sg = 7'b1110000;
            4'd8: sg = 7'b1111111;  4'd9: sg = 7'b1111011;
            default: sg = 7'b0000000;
        endcase
    endfunction

    function automatic logic [27:0] ex(input logic [15:0] t);
        return {sg(t[15:12]), sg(t[11:8]), sg(t[7:4]), sg(t[3:0])};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Caller sits at a negedge; hold low 8 cycles, then release 8 cycles.
    task automatic press(input bit s, input bit l);
        if (s) btn_start_n = 1'b0;
        if (l) btn_lap_n = 1'b0;
        repeat (8) @(negedge clk);
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int  nwrap;
        bit  found, s5959, s1738, s2649;

        vecs[0] = '{1'b1, 16'h9999, 16'h5959};
        vecs[1] = '{1'b1, 16'h1234, 16'h1234};
        vecs[2] = '{1'b1, 16'h6A7B, 16'h5959};
        vecs[3] = '{1'b1, 16'h5080, 16'h5050};
        vecs[4] = '{1'b0, 16'h3786, 16'h0000};
        vecs[5] = '{1'b1, 16'h4908, 16'h4908};

        rst = 1'b1; btn_start_n = 1'b1; btn_lap_n = 1'b1;
        mode_down = 1'b0; preset = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_seg", {4'b0, disp}, {4'b0, {4{7'b1111110}}});
        chk("reset_flags", {running, done, lap_hold, wrap}, 4'b0000);

        // Bounce: 3-cycle glitch must not start.
        btn_start_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_start_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_no_run", running, 1'b0);

        // Sustained press: running rises at the 6th edge after first low sample.
        btn_start_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("deb_before", running, 1'b0);
        @(negedge clk);
        chk("deb_latency", running, 1'b1);
        repeat (3) @(negedge clk);
        btn_start_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("release_no_press", running, 1'b1);

        // Lap while running at 00:05.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (disp == ex(16'h0005)) found = 1;
        end
        chk("reach_0005", found, 1'b1);
        press(1'b0, 1'b1);
        chk("lap_set", lap_hold, 1'b1);
        chk("lap_frozen_a", {4'b0, disp}, {4'b0, ex(16'h0005)});
        repeat (20) @(negedge clk);
        chk("lap_frozen_b", {4'b0, disp}, {4'b0, ex(16'h0005)});
        press(1'b0, 1'b1);
        chk("lap_clear", lap_hold, 1'b0);
        chk("lap_live", {4'b0, disp}, {4'b0, ex(16'h0010)});

        // Both buttons together: only start acts.
        press(1'b1, 1'b1);
        chk("both_run", running, 1'b0);
        chk("both_lap", lap_hold, 1'b0);
        chk("both_time", {4'b0, disp}, {4'b0, ex(16'h0010)});

        // Resume keeps the partial second: tick arrives one cycle after restart.
        press(1'b1, 1'b0);
        chk("resume_run", running, 1'b1);
        chk("resume_partial", {4'b0, disp}, {4'b0, ex(16'h0011)});

        // Up count through 59:59 -> 00:00.
        nwrap = 0; found = 0; s5959 = 0; s1738 = 0; s2649 = 0;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge clk);
            if (wrap) nwrap++;
            if (disp == ex(16'h5959)) s5959 = 1;
            if (disp == ex(16'h1738)) s1738 = 1;
            if (disp == ex(16'h2649)) s2649 = 1;
            if (disp == ex(16'h0000)) found = 1;
        end
        chk("wrap_reached", found, 1'b1);
        chk("wrap_at_0000", wrap, 1'b1);
        chk("saw_5959", s5959, 1'b1);
        chk("saw_1738", s1738, 1'b1);
        chk("saw_2649", s2649, 1'b1);
        repeat (15) begin
            @(negedge clk);
            if (wrap) nwrap++;
        end
        chk("wrap_once", nwrap, 1);
        chk("wrap_running", running, 1'b1);
        chk("after_wrap", {4'b0, disp}, {4'b0, ex(16'h0001)});
        press(1'b1, 1'b0);
        chk("stop", running, 1'b0);

        // Countdown from 00:02.
        mode_down = 1'b1; preset = 16'h0002;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b1);
        chk("cd_load", {4'b0, disp}, {4'b0, ex(16'h0002)});
        press(1'b1, 1'b0);
        chk("cd_run", {running, done}, 2'b10);
        chk("cd_t0", {4'b0, disp}, {4'b0, ex(16'h0002)});
        @(negedge clk);
        chk("cd_t1", {4'b0, disp}, {4'b0, ex(16'h0001)});
        repeat (10) @(negedge clk);
        chk("cd_end", {4'b0, disp}, {4'b0, ex(16'h0000)});
        chk("cd_flags", {running, done}, 2'b01);
        repeat (5) @(negedge clk);
        chk("cd_done_hold", done, 1'b1);

        // Start at 00:00 in down mode reloads preset and clears done.
        press(1'b1, 1'b0);
        chk("reload_flags", {running, done}, 2'b10);
        chk("reload_time", {4'b0, disp}, {4'b0, ex(16'h0002)});
        repeat (11) @(negedge clk);
        chk("reload_done", {running, done}, 2'b01);
        preset = 16'h0000;
        press(1'b1, 1'b0);
        chk("zero_preset", {running, done}, 2'b01);

        // Preset clamping through lap-while-stopped.
        for (int i = 0; i < 6; i++) begin
            mode_down = vecs[i].md;
            preset    = vecs[i].pre;
            repeat (2) @(negedge clk);
            press(1'b0, 1'b1);
            chk($sformatf("clamp%0d", i), {4'b0, disp}, {4'b0, ex(vecs[i].exp)});
            chk($sformatf("clamp%0d_done", i), done, 1'b0);
        end

        // Reset mid-count.
        mode_down = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (25) @(negedge clk);
        chk("pre_rst_run", running, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_seg", {4'b0, disp}, {4'b0, {4{7'b1111110}}});
        chk("rst_mid_flags", {running, done, lap_hold, wrap}, 4'b0000);
        repeat (20) @(negedge clk);
        chk("rst_mid_stays", {4'b0, disp}, {4'b0, ex(16'h0000)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_mmss.md
# stopwatch_mmss

Parametrised MM:SS stopwatch and countdown timer driving four 7-segment digits. It is the successor to the board's fixed up-counting clock and adds:
- parametrised clock frequency and debounce length;
- a synchronous reset;
- debounced start/stop and lap/clear buttons;
- a count-down mode from a BCD preset, with a done flag.

It sits between the raw board buttons and the four-digit display.

## Interface
Parameters:
- CLK_HZ, 12000000, `clk` cycles per counted second (minimum 2)
- DEB_CYCLES, 120000, consecutive stable synchronised samples needed to accept a button level change (minimum 1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_start_n  in  1  start/stop button, active-low, asynchronous
- btn_lap_n  in  1  lap/clear button, active-low, asynchronous
- mode_down  in  1  0 = count up, 1 = count down from preset
- preset  in  16  BCD preset {min tens, min units, sec tens, sec units}
- seg_mt, seg_mu, seg_st, seg_su  out  7 each  segments a..g (MSB = a), active-high
- running  out  1  time base advancing
- lap_hold  out  1  display frozen while counting continues
- done  out  1  countdown reached 00:00
- wrap  out  1  one-cycle pulse on 59:59 -> 00:00 in up mode

## Operation
- **Button path.** Each button goes through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after DEB_CYCLES consecutive identical synchronised samples that differ from the current level.
  - A press is a 1->0 transition of the debounced level and produces a single-cycle internal pulse.
- **Time registers.** Four BCD digits: mt 0..5, mu 0..9, st 0..5, su 0..9.
- **Prescaler.** Width is clog2(CLK_HZ).
  - Increments only while `running`.
  - On reaching CLK_HZ-1 it returns to 0 and emits a tick.
  - When stopped it holds its value, so resuming continues the partial second.
- **Preset clamping.** When loaded, tens digits >5 become 5 and units digits >9 become 9.
- **Mode latch.** `mode_down` is latched into an internal mode register only while stopped; changes while running are ignored.
- **Start press while stopped.**
  - Down mode at 00:00: load the clamped preset, clear `done`, then set `running`.
  - If the clamped preset is 00:00, `running` stays 0 and `done` is set.
  - Otherwise: set `running` and clear `done`.
- **Start press while running:** clear `running`. Time and prescaler hold.
- **Up mode tick:** BCD increment with carries su -> st -> mu -> mt. At 59:59 the next tick gives 00:00 and `wrap` pulses for one cycle. Counting continues.
- **Down mode tick:** BCD decrement with borrows. A tick producing 00:00 clears `running` and sets `done` on the same edge. `done` holds until the next start press or `rst`.
- **Lap press while running:** toggles `lap_hold`.
  - Setting it copies the time registers into a display latch.
  - Clearing it returns the display to live time.
- **Lap press while stopped:**
  - clears `lap_hold`, `done` and the prescaler;
  - time becomes 00:00 in up mode, or the clamped preset in down mode.
- **Simultaneous presses:** a start press and a lap press in the same cycle process start only; lap is discarded.
- **Display source:** the display latch when `lap_hold`, else the live time. Segment decode is combinational from that source.
- **Digit encoding** (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, others=0000000 (blank).

## Timing
- **Reset** (`rst` high at a `clk` edge) sets:
  - time = 00:00 and prescaler = 0;
  - debounced levels = 1 (released), synchroniser FFs = 1;
  - `running`=0, `lap_hold`=0, `done`=0, `wrap`=0, mode register = 0;
  - segments all show 1111110.
- **Reset mid-count:** the same state is reached on the next edge. No tick or `wrap` is emitted in that cycle.
- **Press latency:** a physical press stable from edge N gives its press pulse at edge N+2+DEB_CYCLES. `running` changes at that same edge.
- **Tick cadence:** the first tick after start comes CLK_HZ cycles later, counting from the prescaler value held at start. The time registers, `done` and `wrap` all update at the tick edge.
- **Display timing:** segments reflect the new time in the same cycle the registers change. There is no extra register stage.
- **Lap latch timing:** a lap press coinciding with a tick latches the pre-tick time.
- **Bounce:** a level that reverses before DEB_CYCLES samples restarts the stability count and generates no press.

## Test plan
All scenarios use CLK_HZ=10 and DEB_CYCLES=4.
- **Reset:** `rst` 1 cycle -> all four segments 1111110; `running`=0, `done`=0, `lap_hold`=0.
- **Up count and wrap:** start press, run 3600 ticks -> display passes 59:59 then 00:00; `wrap` high exactly 1 cycle; `running` stays 1.
- **Debounce:** `btn_start_n` glitches low for 3 cycles -> no change to `running`. Held low 10 cycles -> `running`=1 at edge 6 after the low begins.
- **Countdown:** `mode_down`=1, preset 16'h0002, lap press then start press -> after 20 cycles time=00:00, `done`=1, `running`=0.
- **Clamping:** preset 16'h9999, mode_down=1, lap press while stopped -> display 59:59.
- **Lap and simultaneous presses:**
  - Lap press while running at 00:05 -> display frozen at 00:05 while internal time advances.
  - Second lap press -> live time shown.
  - Both buttons pressed together -> only `running` toggles.
